// File: rtl/uart_tx_vo.sv
// uart_tx_vo: byte-wide UART transmitter with a one-byte holding register.
// Frame: start bit 0, 8 data bits LSB first, optional even parity, stop bit 1.
// Each bit lasts o clock cycles (1 cycle when o is 0). o is read only during
// the first cycle of each start bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit before the stop bit.
module uart_tx_vo #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in,
   input  logic         wr,
   input  logic [W-1:0] o,
   output logic         out,
   output logic         busy,
   output logic         full
);

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   state_t         state_q, state_d;
   logic [W-1:0]   cnt_q, cnt_d;
   logic [2:0]     idx_q, idx_d;
   logic [W-1:0]   period_q, period_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     hold_q, hold_d;
   logic           full_q, full_d;
   logic           out_q, out_d;
   logic           busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
   logic           parity_q, parity_d;
`endif

   logic [W-1:0]   o_eff;
   logic [W-1:0]   period_eff;
   logic           bit_done;
   logic           transfer;

   // A zero bit period is treated as one cycle; during the first start-bit
   // cycle the live o is used so a new period takes effect immediately.
   assign o_eff      = (o == '0) ? ONE : o;
   assign period_eff = (state_q == START && cnt_q == '0) ? o_eff : period_q;
   assign bit_done   = (cnt_q == period_eff - ONE);

   // Next-state logic: bit timing, frame sequencing and holding-register handshake.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      period_d = period_q;
      shift_d  = shift_q;
      hold_d   = hold_q;
      full_d   = full_q;
      out_d    = out_q;
      busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif
      transfer = 1'b0;

      case (state_q)
         IDLE: begin
            if (full_q) transfer = 1'b1;
         end
         START: begin
            if (cnt_q == '0) period_d = o_eff;
            if (bit_done) begin
               state_d = DATA;
               cnt_d   = '0;
               idx_d   = 3'd0;
               out_d   = shift_q[0];
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = PARITY;
                  out_d   = parity_q;
`else
                  state_d = STOP;
                  out_d   = 1'b1;
`endif
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
                  out_d   = shift_q[1];
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               state_d = STOP;
               cnt_d   = '0;
               out_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               if (full_q) begin
                  transfer = 1'b1;
               end else begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  out_d   = 1'b1;
                  busy_d  = 1'b0;
               end
            end else begin
               cnt_d = cnt_q + ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = 1'b1;
            busy_d  = 1'b0;
         end
      endcase

      // A transfer empties the holding register, so a write can only land when none happens.
      if (transfer) begin
         state_d  = START;
         cnt_d    = '0;
         idx_d    = 3'd0;
         shift_d  = hold_q;
         full_d   = 1'b0;
         out_d    = 1'b0;
         busy_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_d = ^hold_q;
`endif
      end else if (wr && !full_q) begin
         hold_d = in;
         full_d = 1'b1;
      end
   end

   // State register; reset aborts any frame and drops the held byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         period_q <= '0;
         shift_q  <= 8'h00;
         hold_q   <= 8'h00;
         full_q   <= 1'b0;
         out_q    <= 1'b1;
         busy_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         period_q <= period_d;
         shift_q  <= shift_d;
         hold_q   <= hold_d;
         full_q   <= full_d;
         out_q    <= out_d;
         busy_q   <= busy_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign out  = out_q;
   assign busy = busy_q;
   assign full = full_q;

endmodule

// File: tb/tb_uart_tx_vo.sv
// tb_uart_tx_vo: checks uart_tx_vo against a frame-level model of the line.
// Honours UART_TX_PARITY_EN the same way the design does.
module tb_uart_tx_vo;

`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] in  = 8'h00;
   logic       wr  = 1'b0;
   logic [3:0] o   = 4'd5;
   logic       out;
   logic       busy;
   logic       full;

   int n_checks = 0;
   int n_fails  = 0;

   // Reference model: the frame currently on the line plus the held byte.
   bit       m_valid = 1'b0;
   bit       m_active;
   int       m_cyc;
   int       m_period;
   bit       m_bits[0:10];
   bit       m_hold_valid;
   bit [7:0] m_hold;
   bit [7:0] sent_log[$];

   uart_tx_vo #(.W(4)) dut (
      .clk  (clk),
      .rst  (rst),
      .in   (in),
      .wr   (wr),
      .o    (o),
      .out  (out),
      .busy (busy),
      .full (full)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs presented to it.
   always @(posedge clk) begin : model_update
      bit last;
      bit xfer;
      if (rst) begin
         m_active     = 1'b0;
         m_hold_valid = 1'b0;
         m_cyc        = 0;
         m_valid      = 1'b1;
      end else begin
         last = 1'b0;
         if (m_active) begin
            if (m_cyc == 0) m_period = (o == 4'd0) ? 1 : int'(o);
            last = (m_cyc + 1 == NBITS * m_period);
         end
         xfer = m_hold_valid && (!m_active || last);
         if (m_active) begin
            m_cyc++;
            if (last) m_active = 1'b0;
         end
         if (xfer) begin
            m_bits[0] = 1'b0;
            for (int b = 0; b < 8; b++) m_bits[b+1] = m_hold[b];
`ifdef UART_TX_PARITY_EN
            m_bits[9]  = ^m_hold;
            m_bits[10] = 1'b1;
`else
            m_bits[9]  = 1'b1;
`endif
            m_active     = 1'b1;
            m_cyc        = 0;
            m_hold_valid = 1'b0;
            sent_log.push_back(m_hold);
         end else if (wr && !m_hold_valid) begin
            m_hold       = in;
            m_hold_valid = 1'b1;
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin : compare
      logic exp_out;
      if (m_valid) begin
         if (m_active) exp_out = m_bits[(m_cyc == 0) ? 0 : (m_cyc / m_period)];
         else          exp_out = 1'b1;
         check_output("model_out",  {31'd0, out},  {31'd0, exp_out});
         check_output("model_busy", {31'd0, busy}, {31'd0, m_active});
         check_output("model_full", {31'd0, full}, {31'd0, m_hold_valid});
      end
   end

   task automatic pulse_wr(input logic [7:0] b);
      wr = 1'b1;
      in = b;
      @(negedge clk);
      wr = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr  = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sent_log.delete();
   endtask

   // Count consecutive busy cycles starting at the current falling edge.
   task automatic measure_busy(output int n);
      n = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         n++;
         @(negedge clk);
      end
   endtask

   // Random traffic with occasional period changes and resets.
   task automatic apply_stimulus(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         wr  = ($urandom_range(0, 99) < 8);
         in  = 8'($urandom);
         rst = ($urandom_range(0, 999) == 0);
         if ($urandom_range(0, 199) == 0) o = 4'($urandom_range(0, 15));
         @(negedge clk);
      end
      wr  = 1'b0;
      rst = 1'b0;
   endtask

   int  cnt;
   bit  got[0:10];
`ifdef UART_TX_PARITY_EN
   bit  exp_a5[0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
`else
   bit  exp_a5[0:10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0};
`endif

   initial begin
      // Reset state.
      @(negedge clk);
      do_reset();
      check_output("reset_out",  {31'd0, out},  32'd1);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_full", {31'd0, full}, 32'd0);

      // Single frame 0xA5 at 5 cycles per bit, with latency checks.
      o = 4'd5;
      pulse_wr(8'hA5);
      check_output("lat_full",     {31'd0, full}, 32'd1);
      check_output("lat_busy_pre", {31'd0, busy}, 32'd0);
      @(negedge clk);
      check_output("lat_out_start", {31'd0, out},  32'd0);
      check_output("lat_busy",      {31'd0, busy}, 32'd1);
      check_output("lat_full_drop", {31'd0, full}, 32'd0);
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         if (i % 5 == 2 && i / 5 < NBITS) got[i/5] = out;
         cnt++;
         @(negedge clk);
      end
      check_output("a5_busy_len", cnt, NBITS * 5);
      for (int b = 0; b < NBITS; b++)
         check_output($sformatf("a5_bit%0d", b), {31'd0, got[b]}, {31'd0, exp_a5[b]});
      check_output("a5_log_size", sent_log.size(), 1);

`ifdef UART_TX_PARITY_EN
      // Parity of 0xA4 is odd weight, so the parity bit is 1.
      pulse_wr(8'hA4);
      @(negedge clk);
      repeat (47) @(negedge clk);
      check_output("a4_parity", {31'd0, out}, 32'd1);
      repeat (20) @(negedge clk);
`endif

      // Back-to-back frames; a write while full is dropped.
      do_reset();
      o = 4'd5;
      pulse_wr(8'h3C);
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         cnt++;
         if (i == 10) begin wr = 1'b1; in = 8'hC3; end
         if (i == 11) begin wr = 1'b0; check_output("b2b_full_c3", {31'd0, full}, 32'd1); end
         if (i == 20) begin wr = 1'b1; in = 8'hFF; end
         if (i == 21) begin wr = 1'b0; check_output("b2b_full_ff", {31'd0, full}, 32'd1); end
         if (i == NBITS * 5 - 1) check_output("b2b_full_before", {31'd0, full}, 32'd1);
         if (i == NBITS * 5) begin
            check_output("b2b_full_after", {31'd0, full}, 32'd0);
            check_output("b2b_start2",     {31'd0, out},  32'd0);
         end
         @(negedge clk);
      end
      check_output("b2b_busy_len", cnt, 2 * NBITS * 5);
      check_output("b2b_log_size", sent_log.size(), 2);
      if (sent_log.size() == 2) begin
         check_output("b2b_byte0", {24'd0, sent_log[0]}, 32'h3C);
         check_output("b2b_byte1", {24'd0, sent_log[1]}, 32'hC3);
      end

      // Period change mid-frame only affects the following frame; o = 0 gives 1-cycle bits.
      do_reset();
      o = 4'd5;
      pulse_wr(8'h96);
      @(negedge clk);
      cnt = 0;
      for (int i = 0; i < 400; i++) begin
         if (!busy) break;
         cnt++;
         if (i == 12) begin o = 4'd8; wr = 1'b1; in = 8'h5A; end
         if (i == 13) wr = 1'b0;
         @(negedge clk);
      end
      check_output("period_busy_len", cnt, NBITS * 5 + NBITS * 8);
      repeat (2) @(negedge clk);
      o = 4'd0;
      pulse_wr(8'h81);
      @(negedge clk);
      measure_busy(cnt);
      check_output("period0_busy_len", cnt, NBITS);

      // Reset mid-frame with a held byte aborts everything.
      do_reset();
      o = 4'd5;
      pulse_wr(8'h11);
      @(negedge clk);
      for (int i = 0; i < 40; i++) begin
         if (i == 15) begin wr = 1'b1; in = 8'h22; end
         if (i == 16) begin wr = 1'b0; check_output("rst_full_pre", {31'd0, full}, 32'd1); end
         if (i == 20) rst = 1'b1;
         if (i == 21) begin
            rst = 1'b0;
            check_output("rst_out",  {31'd0, out},  32'd1);
            check_output("rst_busy", {31'd0, busy}, 32'd0);
            check_output("rst_full", {31'd0, full}, 32'd0);
            break;
         end
         @(negedge clk);
      end
      cnt = 0;
      for (int i = 0; i < 150; i++) begin
         if (busy) cnt++;
         @(negedge clk);
      end
      check_output("rst_no_frame", cnt, 0);

      // Reset wins over a simultaneous write.
      rst = 1'b1;
      wr  = 1'b1;
      in  = 8'h77;
      @(negedge clk);
      rst = 1'b0;
      wr  = 1'b0;
      check_output("rst_wr_full", {31'd0, full}, 32'd0);
      @(negedge clk);
      check_output("rst_wr_busy", {31'd0, busy}, 32'd0);

      // Randomized traffic checked cycle by cycle against the model.
      apply_stimulus(6000);
      repeat (200) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
